sia_rxq_wm: RTL and testbench

SIA_RXQ_WM -- requirements
Module: sia_rxq_wm

---
 rtl/sia_rxq_wm.sv | 132 +++++++++++++
 tb/tb_sia_rxq_wm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sia_rxq_wm.sv
// Receive queue behind sia_receiver: each rising edge of rx_idle_i pushes one word, with a
// watermark, a sticky overrun flag and an optional idle timeout (macro SIA_RXQ_TIMEOUT_EN).
module sia_rxq_wm #(
  parameter int DATA_BITS     = 16,
  parameter int DEPTH_BITS    = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [DATA_BITS-1:0]     rx_dat_i,
  input  logic                     rx_idle_i,
  input  logic [DEPTH_BITS:0]      threshold_i,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
  input  logic                     pop_i,
  input  logic                     oe_i,
  input  logic                     clr_ovr_i,
  output logic [DATA_BITS-1:0]     dat_o,
  output logic                     full_o,
  output logic                     not_empty_o,
  output logic [DEPTH_BITS:0]      level_o,
  output logic                     wm_o,
  output logic                     ovr_o,
  output logic                     timeout_o
);

  localparam int Depth = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FullLevel = Depth[DEPTH_BITS:0];
  localparam logic [DEPTH_BITS:0] LevelOne  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS-1:0] PtrOne  = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

  logic [DATA_BITS-1:0]  mem_q [Depth];
  logic [DEPTH_BITS-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [DEPTH_BITS:0]   level_q, level_d;
  logic                  idleDly_q;
  logic                  ovr_q, ovr_d;
  logic                  push, isFull, isEmpty, popOk, pushOk;

  // A push into a full queue is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    push    = rx_idle_i & ~idleDly_q;
    isFull  = (level_q == FullLevel);
    isEmpty = (level_q == '0);
    popOk   = pop_i & ~isEmpty;
    pushOk  = push & (~isFull | popOk);

    wrPtr_d = pushOk ? wrPtr_q + PtrOne : wrPtr_q;
    rdPtr_d = popOk  ? rdPtr_q + PtrOne : rdPtr_q;

    level_d = level_q;
    if (pushOk && !popOk) begin
      level_d = level_q + LevelOne;
    end else if (!pushOk && popOk) begin
      level_d = level_q - LevelOne;
    end

    ovr_d = ovr_q;
    if (push && isFull && !popOk) begin
      ovr_d = 1'b1;
    end else if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
  end

  // idleDly resets high so a receiver that is already idle does not look like a new frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
      ovr_q     <= 1'b0;
      idleDly_q <= 1'b1;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      level_q   <= level_d;
      ovr_q     <= ovr_d;
      idleDly_q <= rx_idle_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= rx_dat_i;
    end
  end

  assign dat_o       = oe_i ? mem_q[rdPtr_q] : '0;
  assign level_o     = level_q;
  assign full_o      = isFull;
  assign not_empty_o = ~isEmpty;
  assign wm_o        = (threshold_i != '0) && (level_q >= threshold_i);
  assign ovr_o       = ovr_q;

`ifdef SIA_RXQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] toCnt_q, toCnt_d;
  logic                     toFlag_q, toFlag_d;

  // Any queue activity or an empty queue restarts the stale-data count.
  always_comb begin
    toCnt_d  = toCnt_q;
    toFlag_d = toFlag_q;
    if (pushOk || popOk || isEmpty) begin
      toCnt_d  = '0;
      toFlag_d = 1'b0;
    end else begin
      if (toCnt_q < timeout_i) begin
        toCnt_d = toCnt_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
      end
      if ((timeout_i != '0) && (toCnt_q == timeout_i)) begin
        toFlag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      toCnt_q  <= '0;
      toFlag_q <= 1'b0;
    end else begin
      toCnt_q  <= toCnt_d;
      toFlag_q <= toFlag_d;
    end
  end

  assign timeout_o = toFlag_q;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^timeout_i;
  assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_sia_rxq_wm.sv
// Directed bench for sia_rxq_wm: a vector table for ordering/watermark/empty corners plus
// hand-written sequences for reset, overrun, push-while-full and the optional timeout.
module tb_sia_rxq_wm;

  typedef struct {
    logic        idle;
    logic [15:0] dat;
    logic        pop;
    logic        oe;
    logic        clr;
    logic [4:0]  thr;
    logic        chkDat;
    logic [15:0] expDat;
    logic [4:0]  expLevel;
    logic        expNe;
    logic        expFull;
    logic        expWm;
    logic        expOvr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rxDat = '0;
  logic        rxIdle = 1'b1;
  logic [4:0]  threshold = '0;
  logic [15:0] timeoutIn = '0;
  logic        pop = 1'b0;
  logic        oe = 1'b0;
  logic        clrOvr = 1'b0;
  logic [15:0] datOut;
  logic        full, notEmpty, wm, ovr, timeoutOut;
  logic [4:0]  level;

  int vecCount = 0;
  int missCount = 0;
  vec_t vecs[18];

  sia_rxq_wm dut (
    .clk_i(clk), .reset_i(reset), .rx_dat_i(rxDat), .rx_idle_i(rxIdle),
    .threshold_i(threshold), .timeout_i(timeoutIn), .pop_i(pop), .oe_i(oe),
    .clr_ovr_i(clrOvr), .dat_o(datOut), .full_o(full), .not_empty_o(notEmpty),
    .level_o(level), .wm_o(wm), .ovr_o(ovr), .timeout_o(timeoutOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs settle, dat_o is checked against the pre-edge head, then flags after the edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    rxIdle = v.idle; rxDat = v.dat; pop = v.pop; oe = v.oe; clrOvr = v.clr; threshold = v.thr;
    #1;
    if (v.chkDat) checkOutput($sformatf("vec%0d dat", idx), 32'(datOut), 32'(v.expDat));
    tick();
    checkOutput($sformatf("vec%0d level", idx), 32'(level), 32'(v.expLevel));
    checkOutput($sformatf("vec%0d notEmpty", idx), 32'(notEmpty), 32'(v.expNe));
    checkOutput($sformatf("vec%0d full", idx), 32'(full), 32'(v.expFull));
    checkOutput($sformatf("vec%0d wm", idx), 32'(wm), 32'(v.expWm));
    checkOutput($sformatf("vec%0d ovr", idx), 32'(ovr), 32'(v.expOvr));
  endtask

  task automatic pushWord(input logic [15:0] d, input logic clr);
    rxIdle = 1'b0;
    tick();
    rxIdle = 1'b1; rxDat = d; clrOvr = clr;
    tick();
    clrOvr = 1'b0;
  endtask

  initial begin
    //            idle dat     pop  oe   clr  thr    chk  expDat  lvl    ne   full wm   ovr
    vecs[0]  = '{1'b0, 16'h41, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'h41, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h42, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'h42, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h43, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'h43, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h44, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h44, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'h00, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 16'h41, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h00, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 16'h42, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h00, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 16'h43, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 16'h00, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 16'h44, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 16'h00, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 16'h55, 1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 16'h55, 1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 16'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 16'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 16'h55, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 16'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 16'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 16'h00, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 16'h55, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with an idle receiver, then stay idle: nothing may be pushed.
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    checkOutput("quiet level", 32'(level), 32'd0);
    checkOutput("quiet notEmpty", 32'(notEmpty), 32'd0);
    checkOutput("quiet ovr", 32'(ovr), 32'd0);
    checkOutput("quiet timeout", 32'(timeoutOut), 32'd0);

    for (int i = 0; i < 18; i++) applyStimulus(i, vecs[i]);
    pop = 1'b0; oe = 1'b0; threshold = '0;

    // Fill to 16, then overrun; an overrun coinciding with clear keeps the flag set.
    for (int i = 0; i < 16; i++) pushWord(16'h100 + 16'(i), 1'b0);
    checkOutput("fill level", 32'(level), 32'd16);
    checkOutput("fill full", 32'(full), 32'd1);
    checkOutput("fill ovr", 32'(ovr), 32'd0);
    pushWord(16'h110, 1'b0);
    checkOutput("ovr level", 32'(level), 32'd16);
    checkOutput("ovr set", 32'(ovr), 32'd1);
    pushWord(16'h111, 1'b1);
    checkOutput("ovr clr+push", 32'(ovr), 32'd1);
    clrOvr = 1'b1;
    tick();
    clrOvr = 1'b0;
    checkOutput("ovr cleared", 32'(ovr), 32'd0);
    checkOutput("ovr cleared level", 32'(level), 32'd16);

    // Push and pop together while full.
    rxIdle = 1'b0;
    tick();
    rxIdle = 1'b1; rxDat = 16'h120; pop = 1'b1; oe = 1'b1;
    #1;
    checkOutput("fullpp head", 32'(datOut), 32'h100);
    tick();
    pop = 1'b0;
    checkOutput("fullpp level", 32'(level), 32'd16);
    checkOutput("fullpp ovr", 32'(ovr), 32'd0);
    checkOutput("fullpp next head", 32'(datOut), 32'h101);
    for (int i = 1; i < 16; i++) begin
      pop = 1'b1;
      #1;
      checkOutput($sformatf("drain%0d", i), 32'(datOut), 32'h100 + 32'(i));
      tick();
    end
    checkOutput("drain last", 32'(datOut), 32'h120);
    tick();
    pop = 1'b0;
    checkOutput("drain level", 32'(level), 32'd0);
    checkOutput("drain notEmpty", 32'(notEmpty), 32'd0);
    oe = 1'b0;

    // Stale-data timeout.
    timeoutIn = 16'd10;
    pushWord(16'h77, 1'b0);
    checkOutput("to after push", 32'(timeoutOut), 32'd0);
`ifdef SIA_RXQ_TIMEOUT_EN
    for (int k = 1; k <= 11; k++) begin
      tick();
      checkOutput($sformatf("to clk%0d", k), 32'(timeoutOut), (k == 11) ? 32'd1 : 32'd0);
    end
    repeat (3) tick();
    checkOutput("to held", 32'(timeoutOut), 32'd1);
`else
    repeat (15) tick();
    checkOutput("to disabled", 32'(timeoutOut), 32'd0);
`endif
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checkOutput("to after pop", 32'(timeoutOut), 32'd0);
    checkOutput("to level", 32'(level), 32'd0);

    // A push landing on reset assertion must be discarded.
    rxIdle = 1'b0;
    tick();
    rxIdle = 1'b1; rxDat = 16'h99; reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("rst push level", 32'(level), 32'd0);
    checkOutput("rst push notEmpty", 32'(notEmpty), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
